sha1_digest_viewer: RTL and testbench
=====================================

Name: sha1_digest_viewer

Overview:
- Output-side reader for the SHA-1 core. It captures the 160-bit digest when the core signals completion.
- The digest is presented one byte at a time on the 8 board LEDs.
- Two board push buttons, synchronised and debounced in this block, step the displayed byte forward and backward.
- Sits between the SHA-1 core's digest port and the LED/push-button pins of the board top level.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles before a button level is accepted (10 ms at 50 MHz); legal range 2..2^20-1.
- DIGEST_BYTES, 20, number of bytes in the digest; fixed at 20 for SHA-1 and not to be overridden.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- push_button  input  2  raw board buttons, active-low, asynchronous; [0]=next byte, [1]=previous byte.
- digest_in  input  160  digest from the SHA-1 core, H0 in bits [159:128].
- digest_valid  input  1  single-cycle strobe from the core; digest_in is valid in that cycle.
- digest_ack  output  1  one-cycle pulse, the cycle after the capture.
- loaded  output  1  high once a digest is held.
- byte_index  output  5  index of the displayed byte, 0..19.
- q  output  8  LED drive, registered.

Behaviour:
Reset values:
- All outputs: q=8'h00, byte_index=0, loaded=0, digest_ack=0.
- Digest register cleared to 0.
- Synchronisers and debounced levels set to "released" (logic 1).
- Debounce counters cleared to 0.

Input conditioning, per button:
- 2-FF synchroniser.
- Debounce counter resets to 0 whenever the synced level equals the debounced level. Otherwise it increments.
- When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced level takes the synced level and the counter clears.
- A press event is a one-cycle pulse on a 1->0 transition of the debounced level. Release generates no event.
- Holding a button gives exactly one event.

State machine:
- EMPTY (loaded=0): button events are ignored and q=8'h00.
- LOADED (loaded=1).
- Any state with digest_valid=1: the digest register captures digest_in, byte_index=0, state=LOADED, and digest_ack=1 on the next cycle.
- In LOADED, a next event with no prev event in the same cycle: byte_index = (byte_index==19) ? 0 : byte_index+1.
- In LOADED, a prev event with no next event in the same cycle: byte_index = (byte_index==0) ? 19 : byte_index-1.
- Both events in the same cycle: ignored, byte_index unchanged.
- digest_valid in the same cycle as a button event: capture wins, byte_index=0, and the event is dropped.
- There is no path back to EMPTY except reset.

Byte order:
- Byte k = digest_reg[159-8k -: 8], so byte 0 is the MSB of H0 (the standard hex print order).

Output timing:
- q is registered and reflects the byte selected by the current byte_index, with a 1-cycle lag behind byte_index.
- After a capture, q shows byte 0 of the new digest two cycles after the digest_valid cycle.

Button latency:
- raw press -> synced after 2 cycles -> debounced after a further DEBOUNCE_CYCLES cycles -> byte_index updates 1 cycle later -> q updates 1 cycle after that.

Glitch rejection:
- A raw glitch shorter than DEBOUNCE_CYCLES synced cycles produces no event.

Reset mid-operation:
- Asserting reset at any point (mid-debounce, during a digest_valid) forces all reset values immediately and asynchronously.
- No event or capture from that cycle survives.
- Deassertion is synchronised by the top-level reset logic, not in this block.

Test Plan:
1. Reset asserted mid-sequence -> q=0x00, byte_index=0, loaded=0, digest_ack=0 immediately; button presses before any digest leave q=0x00.
2. digest_in=a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d with a one-cycle digest_valid -> digest_ack pulses one cycle later, loaded=1, q=0xA9 at valid+2.
3. With DEBOUNCE_CYCLES=4: press button[0] cleanly for 10 cycles -> exactly one event, byte_index=1, q=0x99. A 2-cycle low glitch produces no change.
4. From index 0, press button[1] -> byte_index=19, q=0x9D. Then press button[0] -> byte_index=0, q=0xA9. This covers wrap in both directions.
5. Both buttons debounced-pressed in the same cycle -> byte_index unchanged.
6. A new digest_valid arrives in the same cycle as a next event at index 5 -> byte_index=0 and q shows the new byte 0.

Source files
------------

// File: rtl/sha1_digest_viewer_if.sv
// Digest hand-off between the SHA-1 core and the digest viewer.
// The core drives the digest and its one-cycle valid strobe.
// The viewer answers with a one-cycle acknowledge.
interface sha1_digest_viewer_if;
  logic [159:0] digest_in;
  logic         digest_valid;
  logic         digest_ack;

  modport master (output digest_in, output digest_valid, input digest_ack);
  modport slave  (input digest_in, input digest_valid, output digest_ack);
endinterface

// File: rtl/sha1_digest_viewer.sv
// SHA-1 digest viewer.
// Captures the 160-bit digest when the core strobes valid and shows one byte on the LEDs.
// Two debounced active-low push buttons step the displayed byte forward and backward.
module sha1_digest_viewer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DIGEST_BYTES    = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              push_button,
  sha1_digest_viewer_if.slave     dig,
  output logic                    loaded,
  output logic [4:0]              byte_index,
  output logic [7:0]              q
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]      LAST_IDX = 5'(DIGEST_BYTES - 1);

  typedef enum logic {EMPTY, LOADED} state_t;

  state_t                 state, state_nx;
  logic [1:0]             sync_a, sync_b;
  logic [1:0]             deb, deb_d;
  logic [1:0][CNT_W-1:0]  cnt;
  logic [1:0]             evt;
  logic                   next_evt, prev_evt;
  logic [4:0]             idx_nx;
  logic [159:0]           digest_reg;

  // Byte k is taken MSB-first so byte 0 is the top byte of H0.
  function automatic logic [7:0] byte_sel(input logic [159:0] d, input logic [4:0] k);
    logic [159:0] s;
    s = d >> (8 * (DIGEST_BYTES - 1 - int'(k)));
    return s[7:0];
  endfunction

  // Synchronise the raw buttons and debounce each one against its accepted level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 2'b11;
      sync_b <= 2'b11;
      deb    <= 2'b11;
      deb_d  <= 2'b11;
      cnt    <= '0;
    end else begin
      sync_a <= push_button;
      sync_b <= sync_a;
      deb_d  <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the falling edge of the debounced level; a release makes no event.
  assign evt      = deb_d & ~deb;
  assign next_evt = evt[0];
  assign prev_evt = evt[1];

  // Next state and index: a capture overrides any button event in the same cycle.
  always_comb begin
    state_nx = state;
    idx_nx   = byte_index;
    if (dig.digest_valid) begin
      state_nx = LOADED;
      idx_nx   = '0;
    end else if (state == LOADED) begin
      if (next_evt && !prev_evt) begin
        idx_nx = (byte_index == LAST_IDX) ? 5'd0 : byte_index + 5'd1;
      end else if (prev_evt && !next_evt) begin
        idx_nx = (byte_index == 5'd0) ? LAST_IDX : byte_index - 5'd1;
      end
    end
  end

  // State, index, acknowledge and digest capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= EMPTY;
      byte_index     <= '0;
      dig.digest_ack <= 1'b0;
      digest_reg     <= '0;
    end else begin
      state          <= state_nx;
      byte_index     <= idx_nx;
      dig.digest_ack <= dig.digest_valid;
      if (dig.digest_valid) begin
        digest_reg <= dig.digest_in;
      end
    end
  end

  // LED byte follows the current index one cycle later; dark until a digest is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 8'h00;
    end else begin
      q <= (state == LOADED) ? byte_sel(digest_reg, byte_index) : 8'h00;
    end
  end

  assign loaded = (state == LOADED);

endmodule

// File: tb/tb_sha1_digest_viewer.sv
// Bench for sha1_digest_viewer with a short debounce window.
module tb_sha1_digest_viewer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] push_button = 2'b11;
  logic       loaded;
  logic [4:0] byte_index;
  logic [7:0] q;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [159:0] DIG_A = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_B = 160'h01234567_89abcdef_fedcba98_76543210_11223344;

  sha1_digest_viewer_if dig();

  sha1_digest_viewer #(.DEBOUNCE_CYCLES(4), .DIGEST_BYTES(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .push_button (push_button),
    .dig         (dig.slave),
    .loaded      (loaded),
    .byte_index  (byte_index),
    .q           (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] btn;      // bit0 = next, bit1 = prev (1 = pressed)
    int         hold;     // cycles held low
    logic [4:0] exp_idx;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [1:0] btn, input int hold);
    @(negedge clk);
    push_button = ~btn;
    repeat (hold) @(negedge clk);
    push_button = 2'b11;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 10, 5'd1,  8'h99};  // clean next
    vecs[1]  = '{2'b01, 2,  5'd1,  8'h99};  // short glitch ignored
    vecs[2]  = '{2'b01, 10, 5'd2,  8'h3e};
    vecs[3]  = '{2'b10, 10, 5'd1,  8'h99};
    vecs[4]  = '{2'b10, 10, 5'd0,  8'ha9};
    vecs[5]  = '{2'b10, 10, 5'd19, 8'h9d};  // wrap backward
    vecs[6]  = '{2'b01, 10, 5'd0,  8'ha9};  // wrap forward
    vecs[7]  = '{2'b11, 10, 5'd0,  8'ha9};  // both together ignored
    vecs[8]  = '{2'b10, 10, 5'd19, 8'h9d};
    vecs[9]  = '{2'b10, 10, 5'd18, 8'hd8};
    vecs[10] = '{2'b01, 10, 5'd19, 8'h9d};
    vecs[11] = '{2'b01, 10, 5'd0,  8'ha9};

    dig.digest_in    = '0;
    dig.digest_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_q",      32'(q),              32'h00);
    check("reset_idx",    32'(byte_index),     32'd0);
    check("reset_loaded", 32'(loaded),         32'd0);
    check("reset_ack",    32'(dig.digest_ack), 32'd0);
    reset = 1'b0;

    // Buttons before any digest are ignored
    press(2'b01, 10);
    press(2'b10, 10);
    check("empty_q",      32'(q),          32'h00);
    check("empty_idx",    32'(byte_index), 32'd0);
    check("empty_loaded", 32'(loaded),     32'd0);

    // Capture digest A
    @(negedge clk);
    dig.digest_in    = DIG_A;
    dig.digest_valid = 1'b1;
    @(negedge clk);
    dig.digest_valid = 1'b0;
    check("cap_ack",    32'(dig.digest_ack), 32'd1);
    check("cap_loaded", 32'(loaded),         32'd1);
    check("cap_idx",    32'(byte_index),     32'd0);
    @(negedge clk);
    check("cap_q",       32'(q),              32'ha9);
    check("cap_ack_low", 32'(dig.digest_ack), 32'd0);

    // Table of button sequences
    for (int i = 0; i < 12; i++) begin
      press(vecs[i].btn, vecs[i].hold);
      check($sformatf("vec%0d_idx", i), 32'(byte_index), 32'(vecs[i].exp_idx));
      check($sformatf("vec%0d_q", i),   32'(q),          32'(vecs[i].exp_q));
    end

    // Step to index 5
    for (int i = 0; i < 5; i++) press(2'b01, 10);
    check("idx5",   32'(byte_index), 32'd5);
    check("idx5_q", 32'(q),          32'h06);

    // New digest lands in the same cycle as a next event
    @(negedge clk);
    push_button = 2'b10;
    repeat (6) @(negedge clk);
    dig.digest_in    = DIG_B;
    dig.digest_valid = 1'b1;
    @(negedge clk);
    dig.digest_valid = 1'b0;
    check("race_idx", 32'(byte_index),     32'd0);
    check("race_ack", 32'(dig.digest_ack), 32'd1);
    @(negedge clk);
    check("race_q", 32'(q), 32'h01);
    repeat (4) @(negedge clk);
    push_button = 2'b11;
    repeat (12) @(negedge clk);
    check("race_idx_after", 32'(byte_index), 32'd0);
    press(2'b01, 10);
    check("newdig_idx1", 32'(byte_index), 32'd1);
    check("newdig_q1",   32'(q),          32'h23);

    // Asynchronous reset mid-debounce
    @(negedge clk);
    push_button = 2'b10;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_q",      32'(q),              32'h00);
    check("areset_idx",    32'(byte_index),     32'd0);
    check("areset_loaded", 32'(loaded),         32'd0);
    check("areset_ack",    32'(dig.digest_ack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    push_button = 2'b11;
    repeat (12) @(negedge clk);
    check("post_reset_q",      32'(q),          32'h00);
    check("post_reset_idx",    32'(byte_index), 32'd0);
    check("post_reset_loaded", 32'(loaded),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
